// File: rtl/noc_link_pkg.sv
// Shared types and helpers for the registered, credit-based NoC link and its protocol monitor.
package noc_link_pkg;

    localparam int DEF_FLIT_WIDTH        = 64;
    localparam int DEF_DEST_WIDTH        = 4;
    localparam int DEF_FLIT_BUFFER_DEPTH = 2;
    localparam int CREDIT_W              = $clog2(DEF_FLIT_BUFFER_DEPTH + 1);

    typedef struct packed {
        logic [DEF_FLIT_WIDTH-1:0] data;
        logic [DEF_DEST_WIDTH-1:0] dest;
        logic                      is_tail;
        logic                      send;
    } flit_bundle_t;

    typedef enum logic {
        PKT_IDLE  = 1'b0,
        PKT_INPKT = 1'b1
    } pkt_state_t;

    // Counter width able to hold 0..depth credits.
    function automatic int credit_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/noc_pipeline_link_mon_if.sv
// Link-side signal bundle: upstream flit/credit pair and downstream flit/credit pair.
interface noc_pipeline_link_mon_if #(
    parameter int FLIT_WIDTH = 64,
    parameter int DEST_WIDTH = 4
);
    logic [FLIT_WIDTH-1:0] data_in;
    logic [DEST_WIDTH-1:0] dest_in;
    logic                  is_tail_in;
    logic                  send_in;
    logic                  credit_out;
    logic [FLIT_WIDTH-1:0] data_out;
    logic [DEST_WIDTH-1:0] dest_out;
    logic                  is_tail_out;
    logic                  send_out;
    logic                  credit_in;

    // Routers around the link drive it (master); the link itself is the slave.
    modport master (
        output data_in, dest_in, is_tail_in, send_in, credit_in,
        input  data_out, dest_out, is_tail_out, send_out, credit_out
    );

    modport slave (
        input  data_in, dest_in, is_tail_in, send_in, credit_in,
        output data_out, dest_out, is_tail_out, send_out, credit_out
    );
endinterface

// File: rtl/noc_link_delay.sv
// Reset-to-zero shift register of STAGES registers; STAGES=0 degenerates to a wire.
module noc_link_delay #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    genvar gi;
    generate
        if (STAGES == 0) begin : g_wire
            assign q = d;
        end else begin : g_pipe
            for (gi = 0; gi < STAGES; gi++) begin : g_stage
                logic [WIDTH-1:0] stage_reg;
                logic [WIDTH-1:0] stage_next;

                if (gi == 0) begin : g_first
                    assign stage_next = d;
                end else begin : g_rest
                    assign stage_next = g_stage[gi-1].stage_reg;
                end

                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        stage_reg <= '0;
                    end else begin
                        stage_reg <= stage_next;
                    end
                end
            end
            assign q = g_stage[STAGES-1].stage_reg;
        end
    endgenerate

endmodule

// File: rtl/noc_pipeline_link_mon.sv
// Registered credit-based NoC link with inline protocol monitor (credits, framing, traffic counters).
module noc_pipeline_link_mon
    import noc_link_pkg::*;
#(
    parameter int NUM_PIPELINE      = 2,
    parameter int FLIT_WIDTH        = 64,
    parameter int DEST_WIDTH        = 4,
    parameter int FLIT_BUFFER_DEPTH = 2,
    parameter int CNT_WIDTH         = 32
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    noc_pipeline_link_mon_if.slave                     lnk,
    input  logic                                       mon_clear,
    output logic [$clog2(FLIT_BUFFER_DEPTH+1)-1:0]     credits_avail,
    output logic [CNT_WIDTH-1:0]                       flit_count,
    output logic [CNT_WIDTH-1:0]                       pkt_count,
    output logic                                       err_underflow,
    output logic                                       err_overflow,
    output logic                                       err_dest_change
);

    localparam int              CW      = credit_width(FLIT_BUFFER_DEPTH);
    localparam int              BW      = FLIT_WIDTH + DEST_WIDTH + 2;
    localparam logic [CW-1:0]   FULL    = CW'(FLIT_BUFFER_DEPTH);

    logic [BW-1:0] fwd_d;
    logic [BW-1:0] fwd_q;
    logic [0:0]    crd_q;

    assign fwd_d = {lnk.data_in, lnk.dest_in, lnk.is_tail_in, lnk.send_in};
    assign {lnk.data_out, lnk.dest_out, lnk.is_tail_out, lnk.send_out} = fwd_q;
    assign lnk.credit_out = crd_q[0];

    noc_link_delay #(.WIDTH(BW), .STAGES(NUM_PIPELINE)) u_fwd_delay (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (fwd_d),
        .q     (fwd_q)
    );

    noc_link_delay #(.WIDTH(1), .STAGES(NUM_PIPELINE)) u_crd_delay (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (lnk.credit_in),
        .q     (crd_q)
    );

    // Credit accounting uses the credit as the upstream router actually sees it (after the return delay).
    logic [CW-1:0] credits_reg;
    logic          credit_ret;
    logic          underflow_evt;
    logic          overflow_evt;

    assign credit_ret    = crd_q[0];
    assign underflow_evt = lnk.send_in && !credit_ret && (credits_reg == '0);
    assign overflow_evt  = credit_ret && !lnk.send_in && (credits_reg == FULL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credits_reg <= FULL;
        end else begin
            case ({lnk.send_in, credit_ret})
                2'b10:   if (credits_reg != '0)   credits_reg <= credits_reg - 1'b1;
                2'b01:   if (credits_reg != FULL) credits_reg <= credits_reg + 1'b1;
                default: credits_reg <= credits_reg;
            endcase
        end
    end

    pkt_state_t             state_reg;
    logic [DEST_WIDTH-1:0]  dest_reg;
    logic [CNT_WIDTH-1:0]   flit_count_reg;
    logic [CNT_WIDTH-1:0]   pkt_count_reg;
    logic                   err_underflow_reg;
    logic                   err_overflow_reg;
    logic                   err_dest_change_reg;

    // mon_clear wins over any event in the same cycle, including a send_in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg           <= PKT_IDLE;
            dest_reg            <= '0;
            flit_count_reg      <= '0;
            pkt_count_reg       <= '0;
            err_underflow_reg   <= 1'b0;
            err_overflow_reg    <= 1'b0;
            err_dest_change_reg <= 1'b0;
        end else if (mon_clear) begin
            state_reg           <= PKT_IDLE;
            flit_count_reg      <= '0;
            pkt_count_reg       <= '0;
            err_underflow_reg   <= 1'b0;
            err_overflow_reg    <= 1'b0;
            err_dest_change_reg <= 1'b0;
        end else begin
            if (underflow_evt) err_underflow_reg <= 1'b1;
            if (overflow_evt)  err_overflow_reg  <= 1'b1;
            if (lnk.send_in) begin
                flit_count_reg <= flit_count_reg + 1'b1;
                if (lnk.is_tail_in) pkt_count_reg <= pkt_count_reg + 1'b1;
                case (state_reg)
                    PKT_IDLE: begin
                        if (!lnk.is_tail_in) begin
                            state_reg <= PKT_INPKT;
                            dest_reg  <= lnk.dest_in;
                        end
                    end
                    PKT_INPKT: begin
                        if (lnk.dest_in != dest_reg) err_dest_change_reg <= 1'b1;
                        if (lnk.is_tail_in) state_reg <= PKT_IDLE;
                    end
                    default: state_reg <= PKT_IDLE;
                endcase
            end
        end
    end

    assign credits_avail   = credits_reg;
    assign flit_count      = flit_count_reg;
    assign pkt_count       = pkt_count_reg;
    assign err_underflow   = err_underflow_reg;
    assign err_overflow    = err_overflow_reg;
    assign err_dest_change = err_dest_change_reg;

endmodule
